// File: rtl/ast_tensor_job_sequencer.sv
// Job-level controller: loads A then B into the tensor system, starts it and drains X to memory.
// Optional watchdog on WAIT_IDLE/COMPUTE is enabled by defining AST_SEQ_WATCHDOG_EN.
module ast_tensor_job_sequencer #(
  parameter int unsigned DATAWIDTH = 14,
  parameter int unsigned SIZE      = 4,
  parameter int unsigned ADDRW     = 16,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_job_valid,
  output logic                   o_job_ready,
  input  logic [$clog2(SIZE):0]  i_job_q,
  input  logic [$clog2(SIZE):0]  i_job_r,
  input  logic [$clog2(SIZE):0]  i_job_k,
  input  logic                   i_job_relu,
  input  logic [ADDRW-1:0]       i_job_a,
  input  logic [ADDRW-1:0]       i_job_b,
  input  logic [ADDRW-1:0]       i_job_x,
  output logic                   o_mem_ren,
  output logic [ADDRW-1:0]       o_mem_raddr,
  input  logic [DATAWIDTH-1:0]   i_mem_rdata,
  output logic                   o_mem_wen,
  output logic [ADDRW-1:0]       o_mem_waddr,
  output logic [DATAWIDTH-1:0]   o_mem_wdata,
  input  logic                   i_mem_wready,
  output logic                   o_ts_wen,
  output logic                   o_ts_set,
  output logic                   o_ts_relu,
  output logic                   o_ts_start,
  output logic                   o_ts_ren,
  output logic [$clog2(SIZE):0]  o_ts_depth,
  output logic [$clog2(SIZE):0]  o_ts_width,
  output logic [DATAWIDTH-1:0]   o_ts_data_in,
  input  logic                   i_ts_busy,
  input  logic                   i_ts_done,
  input  logic [DATAWIDTH-1:0]   i_ts_data_out,
  output logic                   o_busy,
  output logic                   o_job_done,
  output logic                   o_err
);

  localparam int unsigned DIMW = $clog2(SIZE) + 1;
  localparam int unsigned CW   = 2 * $clog2(SIZE) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT_IDLE, S_START, S_COMPUTE, S_DRAIN, S_FIN
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DIMW-1:0]   r_q, r_r, r_k;
  logic              r_relu;
  logic [ADDRW-1:0]  r_a, r_b, r_x;
  logic [CW-1:0]     r_na, r_nb, r_nx;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_rd_vld, r_rd_set;
  logic              r_err, w_err_nxt;
  logic              w_accept, w_dims_ok, w_wd_expire;

  assign w_accept  = (r_state == S_IDLE) && i_job_valid;
  assign w_dims_ok = (i_job_q != '0) && (i_job_q <= DIMW'(SIZE)) &&
                     (i_job_r != '0) && (i_job_r <= DIMW'(SIZE)) &&
                     (i_job_k != '0) && (i_job_k <= DIMW'(SIZE));

`ifdef AST_SEQ_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] r_wd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd <= '0;
    end else if (w_state_nxt != r_state) begin
      r_wd <= '0;
    end else if (r_state == S_WAIT_IDLE || r_state == S_COMPUTE) begin
      r_wd <= r_wd + WDW'(1);
    end
  end

  assign w_wd_expire = (r_state == S_WAIT_IDLE || r_state == S_COMPUTE) &&
                       (r_wd == WDW'(TIMEOUT - 1));
`else
  assign w_wd_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    o_mem_ren   = 1'b0;
    o_mem_raddr = '0;
    o_mem_wen   = 1'b0;
    o_mem_waddr = '0;
    o_mem_wdata = '0;
    o_ts_start  = 1'b0;
    o_ts_ren    = 1'b0;
    o_ts_relu   = 1'b0;
    o_job_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_job_valid) begin
          if (w_dims_ok) begin
            w_state_nxt = S_LOAD_A;
            w_cnt_nxt   = '0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_LOAD_A: begin
        o_mem_ren   = 1'b1;
        o_mem_raddr = r_a + ADDRW'(r_cnt);
        if (r_cnt == r_na - CW'(1)) begin
          w_state_nxt = S_LOAD_B;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_LOAD_B: begin
        o_mem_ren   = 1'b1;
        o_mem_raddr = r_b + ADDRW'(r_cnt);
        if (r_cnt == r_nb - CW'(1)) begin
          w_state_nxt = S_WAIT_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (w_wd_expire) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else if (!i_ts_busy) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        o_ts_start  = 1'b1;
        o_ts_relu   = r_relu;
        w_state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        o_ts_relu = r_relu;
        if (w_wd_expire) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else if (i_ts_done) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      S_DRAIN: begin
        // Output pops only when memory accepts, so a stall holds both address and data.
        o_ts_relu   = r_relu;
        o_mem_wen   = 1'b1;
        o_mem_waddr = r_x + ADDRW'(r_cnt);
        o_mem_wdata = i_ts_data_out;
        o_ts_ren    = i_mem_wready;
        if (i_mem_wready) begin
          if (r_cnt == r_nx - CW'(1)) begin
            w_state_nxt = S_FIN;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_FIN: begin
        o_job_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_rd_vld <= 1'b0;
      r_rd_set <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
      r_k      <= '0;
      r_relu   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_x      <= '0;
      r_na     <= '0;
      r_nb     <= '0;
      r_nx     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_err    <= w_err_nxt;
      r_rd_vld <= o_mem_ren;
      r_rd_set <= (r_state == S_LOAD_B);
      if (w_accept) begin
        r_q    <= i_job_q;
        r_r    <= i_job_r;
        r_k    <= i_job_k;
        r_relu <= i_job_relu;
        r_a    <= i_job_a;
        r_b    <= i_job_b;
        r_x    <= i_job_x;
        r_na   <= CW'(i_job_q) * CW'(i_job_r);
        r_nb   <= CW'(i_job_r) * CW'(i_job_k);
        r_nx   <= CW'(i_job_q) * CW'(i_job_k);
      end
    end
  end

  // Read data lands one cycle after its request and is forwarded straight into the array.
  assign o_ts_wen     = r_rd_vld;
  assign o_ts_set     = r_rd_vld & r_rd_set;
  assign o_ts_depth   = !r_rd_vld ? '0 : (r_rd_set ? r_k : r_r);
  assign o_ts_width   = !r_rd_vld ? '0 : (r_rd_set ? r_r : r_q);
  assign o_ts_data_in = r_rd_vld ? i_mem_rdata : '0;
  assign o_job_ready  = (r_state == S_IDLE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_err        = r_err;

endmodule

// File: tb/tb_ast_tensor_job_sequencer.sv
// Self-checking bench: memory and tensor-system models around the sequencer, with a matrix-product
// reference; watchdog scenario runs only when AST_SEQ_WATCHDOG_EN is defined.
module tb_ast_tensor_job_sequencer;
  localparam int DW = 14;
  localparam int AW = 16;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          job_valid = 1'b0, job_ready, job_relu = 1'b0;
  logic [2:0]    job_q = '0, job_r = '0, job_k = '0;
  logic [AW-1:0] job_a = '0, job_b = '0, job_x = '0;
  logic          mem_ren, mem_wen, mem_wready;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_rdata, mem_wdata, ts_data_in, ts_data_out;
  logic          ts_wen, ts_set, ts_relu, ts_start, ts_ren, ts_busy, ts_done;
  logic [2:0]    ts_depth, ts_width;
  logic          busy, job_done, err;

  int checks = 0, failures = 0;

  ast_tensor_job_sequencer #(.DATAWIDTH(DW), .SIZE(4), .ADDRW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_job_valid(job_valid), .o_job_ready(job_ready),
    .i_job_q(job_q), .i_job_r(job_r), .i_job_k(job_k), .i_job_relu(job_relu),
    .i_job_a(job_a), .i_job_b(job_b), .i_job_x(job_x),
    .o_mem_ren(mem_ren), .o_mem_raddr(mem_raddr), .i_mem_rdata(mem_rdata),
    .o_mem_wen(mem_wen), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
    .i_mem_wready(mem_wready),
    .o_ts_wen(ts_wen), .o_ts_set(ts_set), .o_ts_relu(ts_relu), .o_ts_start(ts_start),
    .o_ts_ren(ts_ren), .o_ts_depth(ts_depth), .o_ts_width(ts_width),
    .o_ts_data_in(ts_data_in), .i_ts_busy(ts_busy), .i_ts_done(ts_done),
    .i_ts_data_out(ts_data_out), .o_busy(busy), .o_job_done(job_done), .o_err(err)
  );

  // Memory: 1-cycle read latency, write-ready pattern selected per job.
  logic [DW-1:0] mem [65536];
  int wr_mode = 0, drain_cyc = 0;
  always @(posedge clk) begin
    mem_rdata <= mem_ren ? mem[mem_raddr] : '0;
    drain_cyc <= mem_wen ? drain_cyc + 1 : 0;
    case (wr_mode)
      0:       mem_wready <= 1'b1;
      1:       mem_wready <= ($urandom % 4) != 0;
      default: mem_wready <= !(drain_cyc >= 3 && drain_cyc < 6);
    endcase
  end

  // Tensor-system stand-in: returns the reference product in row-major order.
  int  am [16], bm [16], xref [16];
  int  done_cnt = 0, x_idx = 0, busy_cnt = 0, busy_hold = 0;
  bit  done_en = 1'b1;
  logic relu_cap = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      done_cnt <= 0; ts_done <= 1'b0; x_idx <= 0; relu_cap <= 1'b0; busy_cnt <= 0;
    end else begin
      if (ts_start) begin
        relu_cap <= ts_relu; done_cnt <= 2 + int'($urandom % 5); x_idx <= 0;
      end else if (done_cnt != 0) begin
        done_cnt <= done_cnt - 1;
      end
      ts_done <= done_en && (done_cnt == 1);
      if (ts_ren) x_idx <= x_idx + 1;
      if (ts_wen) busy_cnt <= busy_hold;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
  end
  assign ts_busy = (busy_cnt != 0);
  assign ts_data_out = (x_idx < 16) ? DW'((relu_cap && xref[x_idx] < 0) ? 0 : xref[x_idx]) : '0;

  // Passive monitor.
  logic [20:0] got_ts [$];
  logic [29:0] got_wr [$];
  int n_both = 0, n_ren = 0, n_wen = 0, n_done = 0, n_err = 0, n_nready = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (ts_wen) got_ts.push_back({ts_set, ts_depth, ts_width, ts_data_in});
      if (mem_wen && mem_wready) got_wr.push_back({mem_waddr, mem_wdata});
      if (mem_ren && mem_wen) n_both <= n_both + 1;
      if (mem_ren) n_ren <= n_ren + 1;
      if (mem_wen) n_wen <= n_wen + 1;
      if (job_done) n_done <= n_done + 1;
      if (err) n_err <= n_err + 1;
      if (!job_ready) n_nready <= n_nready + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int q, r, k, input bit relu, input logic [AW-1:0] a, b, x);
    @(negedge clk);
    job_valid = 1'b1; job_q = 3'(q); job_r = 3'(r); job_k = 3'(k);
    job_relu = relu; job_a = a; job_b = b; job_x = x;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic prep(input int q, r, k, input logic [AW-1:0] a, b);
    for (int n = 0; n < q * r; n++) mem[16'(a + 16'(n))] = DW'(am[n]);
    for (int n = 0; n < r * k; n++) mem[16'(b + 16'(n))] = DW'(bm[n]);
    for (int i = 0; i < q; i++)
      for (int j = 0; j < k; j++) begin
        xref[i * k + j] = 0;
        for (int t = 0; t < r; t++) xref[i * k + j] += am[i * r + t] * bm[t * k + j];
      end
  endtask

  task automatic run_job(input string nm, input int q, r, k, input bit relu,
                         input logic [AW-1:0] a, b, x);
    int b_ts, b_wr, b_done, b_both, b_err, cyc;
    logic [20:0] ets;
    prep(q, r, k, a, b);
    b_ts = got_ts.size(); b_wr = got_wr.size();
    b_done = n_done; b_both = n_both; b_err = n_err;
    send(q, r, k, relu, a, b, x);
    cyc = 0;
    while (n_done == b_done && cyc < 3000) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    chk({nm, ":done"}, 32'(n_done - b_done), 1);
    chk({nm, ":err"}, 32'(n_err - b_err), 0);
    chk({nm, ":ren_wen"}, 32'(n_both - b_both), 0);
    chk({nm, ":ready"}, {job_ready, busy}, 2'b10);
    chk({nm, ":ts_cnt"}, 32'(got_ts.size() - b_ts), 32'(q * r + r * k));
    for (int n = 0; n < q * r + r * k && b_ts + n < got_ts.size(); n++) begin
      if (n < q * r) ets = {1'b0, 3'(r), 3'(q), DW'(am[n])};
      else           ets = {1'b1, 3'(k), 3'(r), DW'(bm[n - q * r])};
      chk($sformatf("%s:ts%0d", nm, n), 32'(got_ts[b_ts + n]), 32'(ets));
    end
    chk({nm, ":wr_cnt"}, 32'(got_wr.size() - b_wr), 32'(q * k));
    for (int m = 0; m < q * k && b_wr + m < got_wr.size(); m++)
      chk($sformatf("%s:wr%0d", nm, m), 32'(got_wr[b_wr + m]),
          32'({16'(x + 16'(m)), DW'((relu && xref[m] < 0) ? 0 : xref[m])}));
  endtask

  initial begin
    int b_ts, b_err, b_ren, b_wen, b_nr, b_wr, b_done, cyc, q, r, k;
    repeat (3) @(negedge clk);
    chk("rst_ready", {job_ready, busy}, 2'b10);
    chk("rst_outs", {job_done, err, mem_ren, mem_wen, ts_wen, ts_set, ts_relu, ts_start, ts_ren},
        9'b0);
    reset = 1'b0;
    @(negedge clk);

    // T1
    am[0:5] = '{1, 2, 3, 4, 5, 6}; bm[0:5] = '{1, 0, 0, 1, 1, 1};
    run_job("t1", 2, 3, 2, 1'b0, 16'h0100, 16'h0200, 16'h0300);
    chk("t1:x_spec", {xref[0][7:0], xref[1][7:0], xref[2][7:0], xref[3][7:0]}, 32'h04050a0b);

    // T2
    am[0:5] = '{-1, -2, -3, 4, 5, 6};
    busy_hold = 3;
    run_job("t2r", 2, 3, 2, 1'b1, 16'h0100, 16'h0200, 16'h0400);
    run_job("t2n", 2, 3, 2, 1'b0, 16'h0100, 16'h0200, 16'h0500);
    busy_hold = 0;

    // T3: rejected descriptors
    b_err = n_err; b_ren = n_ren; b_wen = n_wen; b_nr = n_nready;
    send(0, 2, 2, 1'b0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    send(5, 2, 2, 1'b0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("t3:err", 32'(n_err - b_err), 2);
    chk("t3:ren", 32'(n_ren - b_ren), 0);
    chk("t3:wen", 32'(n_wen - b_wen), 0);
    chk("t3:notready", 32'(n_nready - b_nr), 0);

    // T4: full-size job with a 3-cycle write stall
    for (int i = 0; i < 16; i++) begin
      am[i] = int'($urandom % 16) - 8; bm[i] = int'($urandom % 16) - 8;
    end
    wr_mode = 2;
    run_job("t4", 4, 4, 4, 1'b0, 16'h1000, 16'h2000, 16'h3000);

    // T5: reset mid LOAD_B, then a clean T1
    wr_mode = 0;
    am[0:5] = '{1, 2, 3, 4, 5, 6}; bm[0:5] = '{1, 0, 0, 1, 1, 1};
    prep(2, 3, 2, 16'h0100, 16'h0200);
    b_ts = got_ts.size();
    send(2, 3, 2, 1'b1, 16'h0100, 16'h0200, 16'h0600);
    cyc = 0;
    while (got_ts.size() < b_ts + 7 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("t5:in_load_b", 32'(cyc < 100), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5:ready", {job_ready, busy}, 2'b10);
    chk("t5:ts_outs", {ts_wen, ts_set, ts_relu, ts_start, ts_ren, ts_depth, ts_width, ts_data_in},
        29'b0);
    chk("t5:mem_outs", {mem_ren, mem_wen}, 2'b0);
    reset = 1'b0;
    @(negedge clk);
    run_job("t5_t1", 2, 3, 2, 1'b0, 16'h0100, 16'h0200, 16'h0300);

    // Random jobs, including an X region that wraps past the top of memory
    for (int j = 0; j < 6; j++) begin
      q = 1 + int'($urandom % 4); r = 1 + int'($urandom % 4); k = 1 + int'($urandom % 4);
      for (int i = 0; i < 16; i++) begin
        am[i] = int'($urandom % 16) - 8; bm[i] = int'($urandom % 16) - 8;
      end
      wr_mode = int'($urandom % 3);
      busy_hold = int'($urandom % 4);
      run_job($sformatf("rnd%0d", j), q, r, k, 1'($urandom), 16'h4000, 16'h4100,
              (j == 0) ? 16'hfffa : 16'($urandom));
    end
    wr_mode = 0; busy_hold = 0;

`ifdef AST_SEQ_WATCHDOG_EN
    // T6: ts_done never arrives
    done_en = 1'b0;
    prep(2, 3, 2, 16'h0100, 16'h0200);
    b_wr = got_wr.size(); b_done = n_done; b_err = n_err;
    send(2, 3, 2, 1'b0, 16'h0100, 16'h0200, 16'h0700);
    cyc = 0;
    while (!ts_start && cyc < 200) begin @(negedge clk); cyc++; end
    cyc = 0;
    while (!err && cyc < 200) begin @(negedge clk); cyc++; end
    chk("t6:err_time", 32'(cyc), 21);
    chk("t6:ready", {job_ready, busy}, 2'b10);
    repeat (2) @(negedge clk);
    chk("t6:err_cnt", 32'(n_err - b_err), 1);
    chk("t6:no_wr", 32'(got_wr.size() - b_wr), 0);
    chk("t6:no_done", 32'(n_done - b_done), 0);
    done_en = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
